// File: rtl/sonar_scheduler_if.sv
// Signal bundle between the sonar round-robin scheduler and its sensor/serial datapath.
// The master modport is the scheduler side.
interface sonar_scheduler_if #(
  parameter int MEAS_W = 12
);
  logic              ligar;
  logic              continuo;
  logic [2:0]        habilita;
  logic [2:0]        medir;
  logic [2:0]        pronto_med;
  logic [1:0]        sel_sensor;
  logic [MEAS_W-1:0] medida;
  logic              partida_tx;
  logic [1:0]        tx_sensor;
  logic [MEAS_W-1:0] tx_medida;
  logic              pronto_tx;
  logic [2:0]        erro;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    input  ligar, continuo, habilita, pronto_med, medida, pronto_tx,
    output medir, sel_sensor, partida_tx, tx_sensor, tx_medida, erro, pronto, db_estado
  );

  modport slave (
    output ligar, continuo, habilita, pronto_med, medida, pronto_tx,
    input  medir, sel_sensor, partida_tx, tx_sensor, tx_medida, erro, pronto, db_estado
  );
endinterface

// File: rtl/sonar_scheduler.sv
// Round-robin sequencer: measures each enabled ultrasonic sensor in turn and ships
// every result over the shared serial transmitter before moving on.
module sonar_scheduler #(
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int PERIOD_CYCLES  = 50_000_000,
  parameter int MEAS_W         = 12
) (
  input logic               clock,
  input logic               reset,
  sonar_scheduler_if.master bus
);
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PE_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PE_W-1:0] PE_LAST = PE_W'(PERIOD_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREP      = 4'd1,
    MEDIR     = 4'd2,
    ESPERA    = 4'd3,
    REGISTRA  = 4'd4,
    TRANSMITE = 4'd5,
    ESPERA_TX = 4'd6,
    PROXIMO   = 4'd7,
    FIM       = 4'd8,
    INTERVALO = 4'd9
  } state_t;

  state_t            state_r;
  logic [2:0]        mask_r;
  logic [1:0]        sel_r;
  logic [1:0]        tx_sensor_r;
  logic [MEAS_W-1:0] tx_medida_r;
  logic [2:0]        erro_r;
  logic [2:0]        medir_r;
  logic              partida_r;
  logic              pronto_r;
  logic [TO_W-1:0]   to_timer_r;
  logic [PE_W-1:0]   pe_timer_r;
  logic [2:0]        first_s;
  logic [2:0]        next_s;

  // Lowest enabled index at or above 'from'; bit 2 of the result flags that one exists.
  function automatic logic [2:0] pick_from(input logic [2:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign first_s = pick_from(bus.habilita, 3'd0);
  assign next_s  = pick_from(mask_r, {1'b0, sel_r} + 3'd1);

  // Sequencer state, timers and every registered output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      mask_r      <= 3'b000;
      sel_r       <= 2'd0;
      tx_sensor_r <= 2'd0;
      tx_medida_r <= {MEAS_W{1'b0}};
      erro_r      <= 3'b000;
      medir_r     <= 3'b000;
      partida_r   <= 1'b0;
      pronto_r    <= 1'b0;
      to_timer_r  <= {TO_W{1'b0}};
      pe_timer_r  <= {PE_W{1'b0}};
    end else begin
      medir_r   <= 3'b000;
      partida_r <= 1'b0;
      pronto_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.ligar) begin
            state_r <= PREP;
          end
        end
        PREP: begin
          mask_r     <= bus.habilita;
          erro_r     <= 3'b000;
          to_timer_r <= {TO_W{1'b0}};
          if (first_s[2]) begin
            sel_r   <= first_s[1:0];
            medir_r <= onehot3(first_s[1:0]);
            state_r <= MEDIR;
          end else begin
            pronto_r <= 1'b1;
            state_r  <= FIM;
          end
        end
        MEDIR: begin
          to_timer_r <= {TO_W{1'b0}};
          state_r    <= ESPERA;
        end
        // A real answer beats a timeout landing on the same cycle.
        ESPERA: begin
          if (bus.pronto_med[sel_r]) begin
            tx_medida_r <= bus.medida;
            state_r     <= REGISTRA;
          end else if (to_timer_r == TO_LAST) begin
            tx_medida_r   <= {MEAS_W{1'b1}};
            erro_r[sel_r] <= 1'b1;
            state_r       <= REGISTRA;
          end else begin
            to_timer_r <= to_timer_r + TO_W'(1'b1);
          end
        end
        REGISTRA: begin
          tx_sensor_r <= sel_r;
          partida_r   <= 1'b1;
          state_r     <= TRANSMITE;
        end
        TRANSMITE: begin
          state_r <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (bus.pronto_tx) begin
            state_r <= PROXIMO;
          end
        end
        PROXIMO: begin
          if (next_s[2]) begin
            sel_r   <= next_s[1:0];
            medir_r <= onehot3(next_s[1:0]);
            state_r <= MEDIR;
          end else begin
            pronto_r <= 1'b1;
            state_r  <= FIM;
          end
        end
        FIM: begin
          pe_timer_r <= {PE_W{1'b0}};
          state_r    <= bus.continuo ? INTERVALO : IDLE;
        end
        INTERVALO: begin
          if (bus.ligar) begin
            state_r <= PREP;
          end else if (!bus.continuo) begin
            state_r <= IDLE;
          end else if (pe_timer_r == PE_LAST) begin
            state_r <= PREP;
          end else begin
            pe_timer_r <= pe_timer_r + PE_W'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.medir      = medir_r;
  assign bus.sel_sensor = sel_r;
  assign bus.partida_tx = partida_r;
  assign bus.tx_sensor  = tx_sensor_r;
  assign bus.tx_medida  = tx_medida_r;
  assign bus.erro       = erro_r;
  assign bus.pronto     = pronto_r;
  assign bus.db_estado  = state_r;
endmodule

// File: tb/tb_sonar_scheduler.sv
// Randomized bench for sonar_scheduler: a reactive sensor/serial environment and an
// event-timing model that predicts every medir pulse, TX frame and pronto of a round.
module tb_sonar_scheduler;
  localparam int T = 20;
  localparam int P = 100;
  localparam int W = 12;

  typedef struct {
    int          s;
    int          c;
    logic [31:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sonar_scheduler_if #(.MEAS_W(W)) bus ();

  sonar_scheduler #(.TIMEOUT_CYCLES(T), .PERIOD_CYCLES(P), .MEAS_W(W)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [2:0]   msk;
  int           dly [3];
  logic [W-1:0] val [3];
  int           txk;
  bit           strays;
  int           abort_frames;

  ev_t exp_m[$], obs_m[$], exp_f[$], obs_f[$];
  int         exp_pronto;
  logic [2:0] exp_erro, obs_erro;
  int f1, f2, f3;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.ligar      = 1'b0;
    bus.pronto_med = 3'b000;
    bus.pronto_tx  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_medir"},     bus.medir,      32'd0);
    check_eq({tag, "_partida"},   bus.partida_tx, 32'd0);
    check_eq({tag, "_pronto"},    bus.pronto,     32'd0);
    check_eq({tag, "_sel"},       bus.sel_sensor, 32'd0);
    check_eq({tag, "_txsensor"},  bus.tx_sensor,  32'd0);
    check_eq({tag, "_txmedida"},  bus.tx_medida,  32'd0);
    check_eq({tag, "_erro"},      bus.erro,       32'd0);
    check_eq({tag, "_db_estado"}, bus.db_estado,  32'd0);
  endtask

  // Round timeline from the rules: medir 2 cycles after ligar, answer/timeout, frame,
  // TX handshake, next sensor 2 cycles after pronto_tx, pronto at the end.
  task automatic predict(input int lig);
    int cur, reg_c, p;
    logic [W-1:0] v;
    exp_m.delete();
    exp_f.delete();
    exp_erro = 3'b000;
    cur = lig + 2;
    for (int i = 0; i < 3; i++) begin
      if (msk[i]) begin
        exp_m.push_back('{s: 1 << i, c: cur, v: 32'd0});
        if (dly[i] >= 1 && dly[i] <= T) begin
          v = val[i];
          reg_c = cur + dly[i] + 1;
        end else begin
          v = {W{1'b1}};
          reg_c = cur + 1 + T;
          exp_erro[i] = 1'b1;
        end
        p = reg_c + 1;
        exp_f.push_back('{s: i, c: p, v: 32'(v)});
        cur = p + txk + 2;
      end
    end
    exp_pronto = cur;
  endtask

  task automatic run_round(input bit do_ligar, input int virt_l, output int f);
    int lig, tx_at, active, nfr;
    int resp_at [3];
    bit seen;
    obs_m.delete();
    obs_f.delete();
    seen = 1'b0;
    f = -1;
    tx_at = -1;
    active = 3;
    nfr = 0;
    obs_erro = 3'b000;
    resp_at = '{-1, -1, -1};
    if (do_ligar) begin
      step();
      idle_inputs();
      bus.ligar = 1'b1;
      bus.habilita = msk;
      lig = cyc;
    end else begin
      lig = virt_l;
    end
    predict(lig);
    for (int n = 0; n < 600; n++) begin
      if (seen || (abort_frames > 0 && nfr >= abort_frames)) break;
      step();
      idle_inputs();
      if (bus.medir != 3'b000) begin
        obs_m.push_back('{s: int'(bus.medir), c: cyc, v: 32'd0});
        for (int i = 0; i < 3; i++) begin
          if (bus.medir[i]) begin
            active = i;
            resp_at[i] = (dly[i] >= 1) ? cyc + dly[i] : -1;
          end
        end
      end
      if (bus.partida_tx) begin
        obs_f.push_back('{s: int'(bus.tx_sensor), c: cyc, v: 32'(bus.tx_medida)});
        tx_at = cyc + txk;
        nfr++;
      end
      if (bus.pronto) begin
        seen = 1'b1;
        f = cyc;
        obs_erro = bus.erro;
        bus.habilita = msk;
      end
      bus.medida = val[bus.sel_sensor];
      for (int i = 0; i < 3; i++) begin
        if (resp_at[i] == cyc) bus.pronto_med[i] = 1'b1;
      end
      if (strays && cyc >= lig + 1 && !seen) begin
        for (int j = 0; j < 3; j++) begin
          if (j != active && $urandom_range(0, 7) == 0) bus.pronto_med[j] = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) bus.ligar = 1'b1;
        if (cyc >= lig + 2) bus.habilita = 3'($urandom);
      end
      if (tx_at == cyc) bus.pronto_tx = 1'b1;
    end
    check_eq("n_medir", obs_m.size(), exp_m.size());
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      check_eq($sformatf("medir_vec[%0d]", i), obs_m[i].s, exp_m[i].s);
      check_eq($sformatf("medir_cyc[%0d]", i), obs_m[i].c - lig, exp_m[i].c - lig);
    end
    check_eq("n_frames", obs_f.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < obs_f.size(); i++) begin
      check_eq($sformatf("tx_sensor[%0d]", i), obs_f[i].s, exp_f[i].s);
      check_eq($sformatf("tx_medida[%0d]", i), obs_f[i].v, exp_f[i].v);
      check_eq($sformatf("tx_cyc[%0d]", i), obs_f[i].c - lig, exp_f[i].c - lig);
    end
    if (abort_frames > 0) begin
      check_eq("abort_reached", nfr, abort_frames);
      check_eq("erro_abort", bus.erro, exp_erro);
    end else begin
      check_eq("round_done", seen, 1'b1);
      check_eq("pronto_cyc", f - lig, exp_pronto - lig);
      check_eq("erro", obs_erro, exp_erro);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int cnt = 0;
    idle_inputs();
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.medir != 3'b000 || bus.partida_tx || bus.pronto) cnt++;
    end
    check_eq(tag, cnt, 0);
  endtask

  initial begin
    idle_inputs();
    bus.continuo = 1'b0;
    bus.habilita = 3'b000;
    bus.medida   = '0;
    strays = 1'b0;
    abort_frames = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    msk = 3'b111; dly = '{10, 10, 10}; val = '{12'h123, 12'h045, 12'h300}; txk = 3;
    run_round(1'b1, 0, f1);
    quiet(5, "quiet_all3");

    msk = 3'b101; dly = '{4, 7, 9}; val = '{12'h321, 12'h654, 12'h987}; txk = 2;
    run_round(1'b1, 0, f1);
    quiet(5, "quiet_101");

    msk = 3'b111; dly = '{3, 0, 6}; val = '{12'h011, 12'h022, 12'h033}; txk = 1;
    run_round(1'b1, 0, f1);
    quiet(5, "quiet_s1_dead");

    msk = 3'b011; dly = '{T, T + 1, 1}; val = '{12'h0AA, 12'h0BB, 12'h0CC}; txk = 2;
    run_round(1'b1, 0, f1);
    quiet(5, "quiet_boundary");

    msk = 3'b000; txk = 1;
    run_round(1'b1, 0, f1);
    quiet(5, "quiet_nomask");

    for (int r = 0; r < 8; r++) begin
      msk = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        dly[i] = $urandom_range(1, T + 4);
        val[i] = W'($urandom);
      end
      txk = $urandom_range(1, 4);
      strays = 1'b1;
      run_round(1'b1, 0, f1);
      quiet(3, "quiet_rand");
    end

    bus.continuo = 1'b1;
    msk = 3'b101; dly = '{5, 5, 8}; val = '{12'h111, 12'h222, 12'h333}; txk = 2;
    strays = 1'b1;
    run_round(1'b1, 0, f1);
    run_round(1'b0, f1 + P, f2);
    idle_inputs();
    repeat (10) step();
    check_eq("db_intervalo", bus.db_estado, 32'd9);
    run_round(1'b1, 0, f3);
    idle_inputs();
    repeat (5) step();
    bus.continuo = 1'b0;
    step();
    check_eq("db_idle_after_drop", bus.db_estado, 32'd0);
    quiet(P + 20, "quiet_after_drop");

    msk = 3'b110; dly = '{5, 0, 5}; val = '{12'h001, 12'h0AB, 12'h5C5}; txk = 4;
    strays = 1'b0;
    abort_frames = 2;
    run_round(1'b1, 0, f1);
    abort_frames = 0;
    idle_inputs();
    step();
    check_eq("db_espera_tx", bus.db_estado, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.pronto_tx = 1'b1;
    step();
    bus.pronto_tx = 1'b0;
    check_eq("db_after_stray_tx", bus.db_estado, 32'd0);
    quiet(30, "quiet_post_reset");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
